writeback_stage_q: RTL and testbench

- Parametrised writeback stage for the accumulator datapath.
- Selects the writeback source (MDR, ALU, immediate or external input) and updates the accumulator with full-load, LLI or SLLI semantics.
- Pushes accumulator snapshots into an output FIFO drained by a valid/ready consumer.
- Raises `stall` to the pipeline when an output write cannot be accepted.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_out_fifo.sv | 60 ++++++
 rtl/writeback_stage_q.sv | 109 ++++++++++
 tb/tb_writeback_stage_q.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: source-select encodings and
// default sizing of the datapath and output queue.
package wb_pkg;

  localparam logic [1:0] SRC_MDR   = 2'd0;
  localparam logic [1:0] SRC_ALU   = 2'd1;
  localparam logic [1:0] SRC_IMM   = 2'd2;
  localparam logic [1:0] SRC_INPUT = 2'd3;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_IMM_W     = 8;
  localparam int DEF_OUT_DEPTH = 4;

endpackage

// File: rtl/wb_out_fifo.sv
// Synchronous FIFO holding accumulator snapshots for the output consumer.
// A push while full is taken only when a pop frees the head in the same cycle;
// a pop while empty is ignored. rdata reads 0 whenever the queue is empty.
module wb_out_fifo
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_OUT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array: written at the tail, never reset (contents gated by count)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_stage_q.sv
// Writeback stage: selects a source, updates the accumulator (full load,
// LLI or SLLI), and queues accumulator snapshots for a valid/ready consumer.
// Optional feature macro: WB_FLAGS_EN adds registered zero_flag / neg_flag.
module writeback_stage_q
  import wb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IMM_W     = DEF_IMM_W,
  parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic [DATA_W-1:0]              in_data,
  input  logic [DATA_W-1:0]              mdr_out,
  input  logic [DATA_W-1:0]              alu_out,
  input  logic [DATA_W-1:0]              imm_out,
  input  logic [1:0]                     regsrc,
  input  logic                           regw,
  input  logic                           isLLI,
  input  logic                           isSLLI,
  input  logic                           outputw,
  output logic [DATA_W-1:0]              acc_out,
  output logic                           stall,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
`ifdef WB_FLAGS_EN
  output logic                           zero_flag,
  output logic                           neg_flag,
`endif
  output logic [$clog2(OUT_DEPTH+1)-1:0] out_count
);

  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] acc_nxt;
  logic              acc_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  // Reset takes priority, so the stage never reports a stall while in reset
  assign stall     = ~reset & outputw & fifo_full & ~pop;
  assign acc_wr    = regw & ~stall;
  assign push      = outputw & ~stall;

  // Writeback source selection
  always_comb begin
    src = mdr_out;
    case (regsrc)
      SRC_MDR:   src = mdr_out;
      SRC_ALU:   src = alu_out;
      SRC_IMM:   src = imm_out;
      SRC_INPUT: src = in_data;
      default:   src = mdr_out;
    endcase
  end

  // Next accumulator value; LLI wins if both immediate modes are asserted
  always_comb begin
    acc_nxt = src;
    if (isLLI) begin
      acc_nxt = {acc_out[DATA_W-1:IMM_W], src[IMM_W-1:0]};
    end else if (isSLLI) begin
      acc_nxt = {acc_out[DATA_W-IMM_W-1:0], src[IMM_W-1:0]};
    end
  end

  // Accumulator register, updated only on an accepted write
  always_ff @(posedge CLK) begin
    if (reset) begin
      acc_out <= '0;
    end else if (acc_wr) begin
      acc_out <= acc_nxt;
    end
  end

`ifdef WB_FLAGS_EN
  // Status flags track the value written by each accepted accumulator write
  always_ff @(posedge CLK) begin
    if (reset) begin
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else if (acc_wr) begin
      zero_flag <= (acc_nxt == '0);
      neg_flag  <= acc_nxt[DATA_W-1];
    end
  end
`endif

  // The snapshot pushed is the accumulator before any same-cycle write
  wb_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (CLK),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (acc_out),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (out_count)
  );

endmodule

// File: tb/tb_writeback_stage_q.sv
// Directed testbench for writeback_stage_q with hand-computed expectations.
module tb_writeback_stage_q;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] in_data, mdr_out, alu_out, imm_out;
  logic [1:0]  regsrc;
  logic        regw, isLLI, isSLLI, outputw, out_ready;
  logic [15:0] acc_out, out_data;
  logic        stall, out_valid;
  logic [2:0]  out_count;
`ifdef WB_FLAGS_EN
  logic        zero_flag, neg_flag;
`endif

  int errors = 0;
  int checks = 0;

  writeback_stage_q #(.DATA_W(16), .IMM_W(8), .OUT_DEPTH(4)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_data   (in_data),
    .mdr_out   (mdr_out),
    .alu_out   (alu_out),
    .imm_out   (imm_out),
    .regsrc    (regsrc),
    .regw      (regw),
    .isLLI     (isLLI),
    .isSLLI    (isSLLI),
    .outputw   (outputw),
    .acc_out   (acc_out),
    .stall     (stall),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef WB_FLAGS_EN
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag),
`endif
    .out_count (out_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_acc(input logic [15:0] v);
    regsrc = 2'd1; alu_out = v; regw = 1'b1;
    step();
    regw = 1'b0;
  endtask

  task automatic push_acc();
    outputw = 1'b1;
    step();
    outputw = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = 16'h0; mdr_out = 16'h0; alu_out = 16'h0; imm_out = 16'h0;
    regsrc = 2'd0; regw = 1'b0; isLLI = 1'b0; isSLLI = 1'b0; outputw = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_acc", acc_out, 32'h0);
    chk("rst_valid", out_valid, 32'h0);
    chk("rst_count", out_count, 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_stall", stall, 32'h0);

    // full load from ALU
    write_acc(16'h1234);
    chk("alu_load", acc_out, 32'h1234);
    chk("alu_load_valid", out_valid, 32'h0);
    chk("alu_load_stall", stall, 32'h0);

    // other sources
    regsrc = 2'd0; mdr_out = 16'h0A0A; regw = 1'b1; step();
    chk("mdr_load", acc_out, 32'h0A0A);
    regsrc = 2'd3; in_data = 16'h5150; step(); regw = 1'b0;
    chk("input_load", acc_out, 32'h5150);

    // LLI then SLLI
    write_acc(16'hAB00);
    regsrc = 2'd2; imm_out = 16'h00CD; isLLI = 1'b1; regw = 1'b1; step();
    chk("lli", acc_out, 32'hABCD);
    isLLI = 1'b0; isSLLI = 1'b1; imm_out = 16'h0012; step();
    chk("slli", acc_out, 32'hCD12);
    isLLI = 1'b1; imm_out = 16'h0077; step();
    chk("lli_priority", acc_out, 32'hCD77);
    regw = 1'b0; isLLI = 1'b0; isSLLI = 1'b0;
    imm_out = 16'h00FF; isLLI = 1'b1; step(); isLLI = 1'b0;
    chk("mode_no_regw", acc_out, 32'hCD77);

    // pop while empty is ignored
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("pop_empty_count", out_count, 32'h0);

    // fill FIFO with 1..4
    for (int v = 1; v <= 4; v++) begin
      write_acc(16'(v));
      push_acc();
    end
    chk("fill_count", out_count, 32'h4);
    chk("fill_valid", out_valid, 32'h1);
    chk("fill_head", out_data, 32'h1);

    // fifth push stalls and blocks the concurrent write
    outputw = 1'b1; regw = 1'b1; regsrc = 2'd1; alu_out = 16'h7777;
    #1;
    chk("full_stall", stall, 32'h1);
    step();
    chk("stall_count", out_count, 32'h4);
    chk("stall_acc", acc_out, 32'h4);
    chk("stall_head", out_data, 32'h1);
    outputw = 1'b0; regw = 1'b0;
    #1;
    chk("stall_release", stall, 32'h0);

    // drain in order
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_%0d", i), out_data, 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 32'h0);
    chk("drain_count", out_count, 32'h0);

    // full with simultaneous push and pop
    for (int v = 5; v <= 8; v++) begin
      write_acc(16'(v));
      push_acc();
    end
    write_acc(16'h0009);
    outputw = 1'b1; out_ready = 1'b1;
    #1;
    chk("pushpop_stall", stall, 32'h0);
    step();
    outputw = 1'b0; out_ready = 1'b0;
    #1;
    chk("pushpop_count", out_count, 32'h4);
    chk("pushpop_head", out_data, 32'h6);
    out_ready = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      chk($sformatf("pushpop_drain_%0d", i), out_data, 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("pushpop_empty", out_valid, 32'h0);

    // same-cycle write and push: pre-update value is queued
    write_acc(16'h0011);
    regsrc = 2'd1; alu_out = 16'h0055; regw = 1'b1; outputw = 1'b1;
    step();
    regw = 1'b0; outputw = 1'b0;
    chk("same_cycle_acc", acc_out, 32'h0055);
    chk("same_cycle_data", out_data, 32'h0011);
    chk("same_cycle_count", out_count, 32'h1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // mid-operation reset discards FIFO and wins over a write
    push_acc(); push_acc(); push_acc();
    chk("pre_reset_count", out_count, 32'h3);
    reset = 1'b1; regw = 1'b1; alu_out = 16'hFFFF; outputw = 1'b1;
    #1;
    chk("reset_stall", stall, 32'h0);
    step();
    reset = 1'b0; regw = 1'b0; outputw = 1'b0;
    #1;
    chk("mid_rst_count", out_count, 32'h0);
    chk("mid_rst_valid", out_valid, 32'h0);
    chk("mid_rst_acc", acc_out, 32'h0);
    chk("mid_rst_data", out_data, 32'h0);

`ifdef WB_FLAGS_EN
    write_acc(16'h0000);
    chk("zero_flag_set", zero_flag, 32'h1);
    chk("neg_flag_clr", neg_flag, 32'h0);
    write_acc(16'h8000);
    chk("zero_flag_clr", zero_flag, 32'h0);
    chk("neg_flag_set", neg_flag, 32'h1);
    step();
    chk("neg_flag_hold", neg_flag, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
